serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes d = a - b, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Serves as the area-minimal subtraction datapath alongside the ripple adder in the arithmetic library.
- Used by compare/decrement paths in the hashing pipeline where latency is cheap and LUTs are not.
- Start/ready/done handshake; result held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: request; sampled only while ready=1.
- a, input, WIDTH: minuend; latched on the accepted start.
- b, input, WIDTH: subtrahend; latched on the accepted start.
- ready, output, 1: high in IDLE only.
- done, output, 1: one-cycle pulse when the result is valid.
- d, output, WIDTH: difference a - b mod 2^WIDTH.
- borrow, output, 1: unsigned borrow out, 1 iff a < b (unsigned).
- ovf, output, 1: signed overflow of a - b.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is asynchronous, active-high.
  - While rst=1: state=IDLE, ready=1, done=0, d=0, borrow=0, ovf=0, and internal shift registers, bit counter and borrow register are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a and b into shift registers, clear the borrow register, set the bit counter to 0, go to RUN.
  - With start=0, stay in IDLE; outputs hold their last values.
- RUN:
  - ready=0.
  - Each edge processes bit i=count using the LSBs of the shift registers (ai, bi, br = borrow register):
    - di = ai ^ bi ^ br
    - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - di shifts into the result register MSB-first, so that after WIDTH shifts result[i]=di.
  - Operand registers shift right; count increments.
  - On the edge processing bit WIDTH-1, go to DONE. On that same edge:
    - d takes the assembled result.
    - borrow = final br_next.
    - ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ d[WIDTH-1]), using the latched operand MSBs (keep a copy).
- DONE:
  - done=1 for exactly this one cycle; ready=0.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - done rises WIDTH edges after the edge that accepted start.
  - Minimum start-to-start spacing is WIDTH+2 edges.
- Outputs:
  - d, borrow and ovf update only on entry to DONE. They are held through IDLE until the next result.
  - d, borrow and ovf are not cleared by a new start; they change only when the new result completes.
- Boundary conditions:
  - start while RUN or DONE is ignored, with no effect on the current operation.
  - Changes on a/b after acceptance have no effect.
  - start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
  - rst asserted mid-RUN: the operation is aborted immediately (asynchronously), all outputs are zeroed, and no done pulse is produced.
  - rst released: first start is accepted on the first rising edge with rst=0.
  - count is wide enough for WIDTH; no wrap occurs inside one operation.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - Unsigned borrow and signed overflow are independent flags; both may be 1 simultaneously.

Test Plan:
- 0x5A - 0x3C, start pulsed in IDLE -> done exactly 8 edges later: d=0x1E, borrow=0, ovf=0; ready low for 9 cycles total.
- 0x00 - 0x01 -> d=0xFF, borrow=1, ovf=0. Then 0xA5 - 0xA5 -> d=0x00, borrow=0, ovf=0.
- Signed overflow cases:
  - 0x80 - 0x01 -> d=0x7F, borrow=0, ovf=1.
  - 0x7F - 0xFF -> d=0x80, borrow=1, ovf=1.
- Start during operation:
  - Accept 0x10 - 0x01, then pulse start with a=0xFF, b=0x00 at cycles 3 and 8 (RUN/DONE) -> single done, d=0x0F.
  - No second done until a new start is issued in IDLE.
- Back-to-back with start held high:
  - 0x20 - 0x10, then operands changed to 0x03 - 0x05 during RUN -> first done d=0x10.
  - Second operation accepted at the first IDLE edge after it uses 0x03/0x05: d=0xFE, borrow=1, second done 10 edges after the first.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) at bit 4 of 0xF0 - 0x0F -> outputs 0 and ready=1 immediately, no done pulse.
  - After release, 0x09 - 0x04 -> d=0x05 after 8 edges.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b, one bit per clock,
// LSB first, built around a single full-subtractor cell and a registered
// borrow. A start/ready/done handshake frames each operation, and the
// result flags stay stable until the next result completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf
);

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] res_sr_reg;
  logic             br_reg;
  logic [CW-1:0]    count_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic             ovf_reg;

  logic             ai;
  logic             bi;
  logic             di;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs plus the assembled result word.
  always_comb begin
    ai       = a_sr_reg[0];
    bi       = b_sr_reg[0];
    di       = ai ^ bi ^ br_reg;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_reg);
    res_next = {di, res_sr_reg[WIDTH-1:1]};
    last_bit = (count_reg == CW'(WIDTH - 1));
  end

  // Sequencer and datapath: latch operands on accept, shift one bit per
  // RUN cycle, publish d/borrow/ovf only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      br_reg     <= 1'b0;
      count_reg  <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            // Operand MSBs are kept aside because the shift registers lose
            // them before the overflow flag is formed.
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            br_reg    <= 1'b0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= res_next;
          br_reg     <= br_next;
          if (last_bit) begin
            d_reg      <= res_next;
            borrow_reg <= br_next;
            // res_next[WIDTH-1] is di of the final bit, i.e. the result MSB.
            ovf_reg    <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ di);
            state_reg  <= DONE;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake is decoded straight from the state so that an asynchronous
  // reset raises ready and drops done without waiting for an edge.
  always_comb begin
    ready  = (state_reg == IDLE);
    done   = (state_reg == DONE);
    d      = d_reg;
    borrow = borrow_reg;
    ovf    = ovf_reg;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. Expected values come from a
// plain-arithmetic model (integer subtraction, unsigned compare, signed
// range test); each scenario task performs its own comparisons.
module tb_serial_subtractor;

  localparam int W    = 8;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] d;
  logic         borrow;
  logic         ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .d      (d),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arithmetic definition of a - b and its flags.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] ed, output logic eb,
                                output logic eo);
    int ux, uy, sx, sy, sd;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > SMAX) ? ux - (1 << W) : ux;
    sy = (uy > SMAX) ? uy - (1 << W) : uy;
    sd = sx - sy;
    ed = W'(ux - uy);
    eb = (ux < uy);
    eo = (sd > SMAX) || (sd < SMIN);
  endfunction

  // Moves to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for done.
  // lat = edges from accept to done; rdy_low = samples with ready low.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int rdy_low);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    rdy_low = (ready === 1'b0) ? 1 : 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      tick();
      lat++;
      if (ready === 1'b0) rdy_low++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (d !== '0) $display("FAIL reset_d got=%h exp=00", d); else pass_cnt++;
    total_cnt++; if (borrow !== 1'b0) $display("FAIL reset_borrow got=%b exp=0", borrow); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [5] = '{8'h5A, 8'h00, 8'hA5, 8'h80, 8'h7F};
    logic [W-1:0] ys [5] = '{8'h3C, 8'h01, 8'hA5, 8'h01, 8'hFF};
    logic [W-1:0] ed;
    logic eb, eo;
    int lat, rl;
    for (int i = 0; i < 5; i++) begin
      model(xs[i], ys[i], ed, eb, eo);
      run_op(xs[i], ys[i], lat, rl);
      $display("op %h - %h : d=%h borrow=%b ovf=%b latency=%0d", xs[i], ys[i], d, borrow, ovf, lat);
      total_cnt++; if (lat != W) $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, W); else pass_cnt++;
      total_cnt++; if (d !== ed) $display("FAIL dir_d[%0d] got=%h exp=%h", i, d, ed); else pass_cnt++;
      total_cnt++; if (borrow !== eb) $display("FAIL dir_borrow[%0d] got=%b exp=%b", i, borrow, eb); else pass_cnt++;
      total_cnt++; if (ovf !== eo) $display("FAIL dir_ovf[%0d] got=%b exp=%b", i, ovf, eo); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (rl != W + 1) $display("FAIL dir_ready_low got=%0d exp=%0d", rl, W + 1); else pass_cnt++;
      end
      tick();
      total_cnt++; if (done !== 1'b0 || ready !== 1'b1)
        $display("FAIL dir_after_done[%0d] got done=%b ready=%b exp done=0 ready=1", i, done, ready);
      else pass_cnt++;
      // Results must be held through IDLE.
      tick();
      total_cnt++; if (d !== ed) $display("FAIL dir_hold_d[%0d] got=%h exp=%h", i, d, ed); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, ed;
    logic eb, eo;
    int lat, rl;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom;
      model(x, y, ed, eb, eo);
      run_op(x, y, lat, rl);
      $display("rnd %h - %h : d=%h borrow=%b ovf=%b latency=%0d", x, y, d, borrow, ovf, lat);
      total_cnt++;
      if (lat != W || d !== ed || borrow !== eb || ovf !== eo)
        $display("FAIL rnd[%0d] got lat=%0d d=%h b=%b o=%b exp lat=%0d d=%h b=%b o=%b",
                 i, lat, d, borrow, ovf, W, ed, eb, eo);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int n, dones;
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    dones = 0;
    for (int k = 0; k < 3 * W; k++) begin
      // Spurious requests in RUN and in DONE with different operands.
      if (n == 3 || done === 1'b1) begin
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
      if (done === 1'b1) dones++;
    end
    $display("ignore 10 - 01 : d=%h dones=%0d", d, dones);
    total_cnt++; if (dones != 1) $display("FAIL ignore_dones got=%0d exp=1", dones); else pass_cnt++;
    total_cnt++; if (d !== 8'h0F) $display("FAIL ignore_d got=%h exp=0f", d); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL ignore_idle got ready=%b exp=1", ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    logic [W-1:0] d1, d2;
    logic b2;
    a = 8'h20;
    b = 8'h10;
    start = 1'b1;
    tick();
    a = 8'h03;
    b = 8'h05;
    n = 0;
    t1 = -1;
    t2 = -1;
    d1 = '0;
    d2 = '0;
    b2 = 1'b0;
    while (t2 < 0 && n < 4 * W) begin
      tick();
      n++;
      if (done === 1'b1) begin
        if (t1 < 0) begin t1 = n; d1 = d; end
        else begin t2 = n; d2 = d; b2 = borrow; end
      end
    end
    start = 1'b0;
    $display("b2b first d=%h at %0d, second d=%h borrow=%b at %0d", d1, t1, d2, b2, t2);
    total_cnt++; if (t1 != W) $display("FAIL b2b_first_latency got=%0d exp=%0d", t1, W); else pass_cnt++;
    total_cnt++; if (d1 !== 8'h10) $display("FAIL b2b_first_d got=%h exp=10", d1); else pass_cnt++;
    total_cnt++; if (t2 - t1 != W + 2) $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, W + 2); else pass_cnt++;
    total_cnt++; if (d2 !== 8'hFE || b2 !== 1'b1)
      $display("FAIL b2b_second got d=%h borrow=%b exp d=fe borrow=1", d2, b2);
    else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int dones, lat, rl;
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    $display("rst mid-run : ready=%b done=%b d=%h borrow=%b ovf=%b", ready, done, d, borrow, ovf);
    total_cnt++; if (ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (d !== '0 || borrow !== 1'b0 || ovf !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_outputs got d=%h b=%b o=%b done=%b exp all 0", d, borrow, ovf, done);
    else pass_cnt++;
    dones = 0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    total_cnt++; if (dones != 0) $display("FAIL rstmid_no_done got=%0d exp=0", dones); else pass_cnt++;
    rst = 1'b0;
    run_op(8'h09, 8'h04, lat, rl);
    $display("after rst 09 - 04 : d=%h latency=%0d", d, lat);
    total_cnt++; if (lat != W) $display("FAIL rstmid_latency got=%0d exp=%0d", lat, W); else pass_cnt++;
    total_cnt++; if (d !== 8'h05) $display("FAIL rstmid_d got=%h exp=05", d); else pass_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
